// File: rtl/fnd_pkg.sv
// Shared definitions for the 4-digit 7-segment scanner.
// Segment codes are active-low, bit 0 = a ... bit 6 = g.
package fnd_pkg;

    localparam int unsigned NUM_DIG = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Non-decimal codes render blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_99.sv
// Combinational 0..99 binary to two-digit BCD converter.
// Ports: bin (7b in), tens/ones (BCD out), ovf (1 when bin >= 100).
module bin2bcd_99 (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       ovf
);

    // Compare/subtract chain from 90 down to 10; first hit wins.
    always_comb begin
        tens = 4'd0;
        ones = bin[3:0];
        ovf  = (bin >= 7'd100);
        for (int t = 9; t >= 1; t--) begin
            if (tens == 4'd0 && bin >= 7'(t * 10)) begin
                tens = 4'(t);
                ones = 4'(bin - 7'(t * 10));
            end
        end
        // Digits are meaningless on overflow; keep them at zero.
        if (ovf) begin
            tens = 4'd0;
            ones = 4'd0;
        end
    end

endmodule

// File: rtl/fnd_scan_4dig.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display
// showing two 0..99 values, with per-frame snapshot and per-slot dead time.
// Ports: clk, rst (async high); val_hi/val_lo (7b values), dp_en (4b),
//   blank_lz (blank hi tens zero); seg_n (8b, [7]=dp), com_n (4b),
//   frame_tick (pulse when a new snapshot is loaded).
module fnd_scan_4dig
    import fnd_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] val_hi,
    input  logic [6:0] val_lo,
    input  logic [3:0] dp_en,
    input  logic       blank_lz,
    output logic [7:0] seg_n,
    output logic [3:0] com_n,
    output logic       frame_tick
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ON  = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       snap_hi_q, snap_hi_d;
    logic [6:0]       snap_lo_q, snap_lo_d;
    logic [3:0]       snap_dp_q, snap_dp_d;
    logic             snap_blz_q, snap_blz_d;
    logic             load_q, load_d;
    logic             frame_tick_q, frame_tick_d;
    logic [7:0]       seg_n_q, seg_n_d;
    logic [3:0]       com_n_q, com_n_d;

    logic [3:0] hi_tens, hi_ones, lo_tens, lo_ones;
    logic       hi_ovf, lo_ovf;
    logic [6:0] dig_seg [NUM_DIG];
    logic       wrap, load, lit;

    bin2bcd_99 u_bcd_hi (
        .bin  (snap_hi_q),
        .tens (hi_tens),
        .ones (hi_ones),
        .ovf  (hi_ovf)
    );

    bin2bcd_99 u_bcd_lo (
        .bin  (snap_lo_q),
        .tens (lo_tens),
        .ones (lo_ones),
        .ovf  (lo_ovf)
    );

    // Per-digit glyphs from the current snapshot; overflow beats blanking.
    always_comb begin
        dig_seg[0] = lo_ovf ? SEG_DASH : bcd_to_seg(lo_ones);
        dig_seg[1] = lo_ovf ? SEG_DASH : bcd_to_seg(lo_tens);
        dig_seg[2] = hi_ovf ? SEG_DASH : bcd_to_seg(hi_ones);
        if (hi_ovf) begin
            dig_seg[3] = SEG_DASH;
        end else if (snap_blz_q && hi_tens == 4'd0) begin
            dig_seg[3] = SEG_BLANK;
        end else begin
            dig_seg[3] = bcd_to_seg(hi_tens);
        end
    end

    always_comb begin
        wrap  = (cnt_q == CNT_MAX);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;

        // Load on the last clock of digit 3 so the new frame starts clean.
        load       = wrap && (idx_q == 2'd3);
        snap_hi_d  = load ? val_hi : snap_hi_q;
        snap_lo_d  = load ? val_lo : snap_lo_q;
        snap_dp_d  = load ? dp_en : snap_dp_q;
        snap_blz_d = load ? blank_lz : snap_blz_q;

        load_d       = load;
        frame_tick_d = load_q;

        // Dead time at the start of each slot keeps the previous digit
        // from ghosting into the next one.
        lit     = (cnt_q >= CNT_ON);
        com_n_d = 4'hF;
        seg_n_d = 8'hFF;
        if (lit) begin
            com_n_d = ~(4'b0001 << idx_q);
            seg_n_d = {~snap_dp_q[idx_q], dig_seg[idx_q]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            snap_hi_q    <= 7'd0;
            snap_lo_q    <= 7'd0;
            snap_dp_q    <= 4'd0;
            snap_blz_q   <= 1'b0;
            load_q       <= 1'b0;
            frame_tick_q <= 1'b0;
            seg_n_q      <= 8'hFF;
            com_n_q      <= 4'hF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_hi_q    <= snap_hi_d;
            snap_lo_q    <= snap_lo_d;
            snap_dp_q    <= snap_dp_d;
            snap_blz_q   <= snap_blz_d;
            load_q       <= load_d;
            frame_tick_q <= frame_tick_d;
            seg_n_q      <= seg_n_d;
            com_n_q      <= com_n_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign com_n      = com_n_q;
    assign frame_tick = frame_tick_q;

endmodule
